// File: rtl/mcu_port_arbiter.sv
// Memory-controller port arbiter: the cache has priority (bounded by a starvation limit),
// DMA channels rotate round-robin, and read grants are held through the data beat window.
module mcu_port_arbiter #(
    parameter int NUM_DMA    = 2,
    parameter int READ_BEATS = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   MCU_CLK,
    input  logic                   RST,
    input  logic                   c_req,
    input  logic                   c_we,
    input  logic [31:0]            c_addr,
    input  logic [31:0]            c_wdata,
    output logic                   c_grant,
    output logic                   c_ack,
    input  logic [NUM_DMA-1:0]     d_req,
    input  logic [NUM_DMA-1:0]     d_we,
    input  logic [32*NUM_DMA-1:0]  d_addr,
    input  logic [32*NUM_DMA-1:0]  d_wdata,
    output logic [NUM_DMA-1:0]     d_grant,
    output logic [NUM_DMA-1:0]     d_ack,
    output logic [31:0]            mem_addr,
    output logic                   mem_we,
    output logic                   mem_do_act,
    output logic [31:0]            mem_dataintomem,
    input  logic                   mem_ack
);
    localparam int RRW = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;
    localparam int BW  = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
    localparam int SW  = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic                     c_grant_q, c_grant_d;
    logic [NUM_DMA-1:0]       d_grant_q, d_grant_d;
    logic                     c_ack_q, c_ack_d;
    logic [NUM_DMA-1:0]       d_ack_q, d_ack_d;
    logic [RRW-1:0]           rr_q, rr_d;
    logic [SW-1:0]            starve_q, starve_d;
    logic [BW-1:0]            beat_q, beat_d;

    logic [NUM_DMA-1:0][31:0] d_addr_a, d_wdata_a;
    logic                     any_dreq, cache_wins;
    logic                     owner_req, owner_we;
    logic [RRW-1:0]           rr_pick, rr_nxt;
    logic [NUM_DMA-1:0]       rr_onehot;
    logic                     rr_hit;

    assign d_addr_a  = d_addr;
    assign d_wdata_a = d_wdata;
    assign any_dreq  = |d_req;
    assign cache_wins = c_req && ((starve_q < SW'(STARVE_MAX)) || !any_dreq);

    assign owner_req = c_grant_q ? c_req : |(d_grant_q & d_req);
    assign owner_we  = c_grant_q ? c_we  : |(d_grant_q & d_we);

    // Round-robin: lowest requesting channel at or above the pointer, else lowest overall.
    always_comb begin
        rr_pick = '0;
        rr_hit  = 1'b0;
        for (int i = NUM_DMA - 1; i >= 0; i--) begin
            if (d_req[i] && (RRW'(i) >= rr_q)) begin
                rr_pick = RRW'(i);
                rr_hit  = 1'b1;
            end
        end
        if (!rr_hit) begin
            for (int i = NUM_DMA - 1; i >= 0; i--) begin
                if (d_req[i]) rr_pick = RRW'(i);
            end
        end
        rr_onehot = '0;
        rr_onehot[rr_pick] = 1'b1;
        rr_nxt = (rr_pick == RRW'(NUM_DMA - 1)) ? '0 : rr_pick + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        c_grant_d = c_grant_q;
        d_grant_d = d_grant_q;
        rr_d      = rr_q;
        starve_d  = starve_q;
        beat_d    = beat_q;
        c_ack_d   = 1'b0;
        d_ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (cache_wins) begin
                    c_grant_d = 1'b1;
                    state_d   = ST_OWN;
                    if (!any_dreq)                          starve_d = '0;
                    else if (starve_q != SW'(STARVE_MAX))   starve_d = starve_q + 1'b1;
                end else if (any_dreq) begin
                    d_grant_d = rr_onehot;
                    rr_d      = rr_nxt;
                    starve_d  = '0;
                    state_d   = ST_OWN;
                end
            end
            ST_OWN: begin
                // An ack coinciding with a request drop still completes the transfer.
                if (mem_ack) begin
                    c_ack_d = c_grant_q;
                    d_ack_d = d_grant_q;
                    if (!owner_we) begin
                        state_d = ST_HOLD;
                        beat_d  = BW'(READ_BEATS - 1);
                    end else begin
                        state_d   = ST_GAP;
                        c_grant_d = 1'b0;
                        d_grant_d = '0;
                    end
                end else if (!owner_req) begin
                    state_d   = ST_GAP;
                    c_grant_d = 1'b0;
                    d_grant_d = '0;
                end
            end
            ST_HOLD: begin
                if (beat_q == '0) begin
                    state_d   = ST_GAP;
                    c_grant_d = 1'b0;
                    d_grant_d = '0;
                end else begin
                    beat_d = beat_q - 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                c_grant_d = 1'b0;
                d_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge MCU_CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            c_grant_q <= 1'b0;
            d_grant_q <= '0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= '0;
            rr_q      <= '0;
            starve_q  <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            c_grant_q <= c_grant_d;
            d_grant_q <= d_grant_d;
            c_ack_q   <= c_ack_d;
            d_ack_q   <= d_ack_d;
            rr_q      <= rr_d;
            starve_q  <= starve_d;
            beat_q    <= beat_d;
        end
    end

    // Owner mux; zero when nobody holds the port.
    always_comb begin
        mem_addr        = '0;
        mem_we          = 1'b0;
        mem_dataintomem = '0;
        if (c_grant_q) begin
            mem_addr        = c_addr;
            mem_we          = c_we;
            mem_dataintomem = c_wdata;
        end else begin
            for (int i = 0; i < NUM_DMA; i++) begin
                if (d_grant_q[i]) begin
                    mem_addr        = mem_addr | d_addr_a[i];
                    mem_we          = mem_we | d_we[i];
                    mem_dataintomem = mem_dataintomem | d_wdata_a[i];
                end
            end
        end
    end

    assign mem_do_act = (state_q == ST_OWN) && owner_req;
    assign c_grant    = c_grant_q;
    assign d_grant    = d_grant_q;
    assign c_ack      = c_ack_q;
    assign d_ack      = d_ack_q;

endmodule

// File: doc/mcu_port_arbiter.md
Name: mcu_port_arbiter

Overview:
- Shares the single memory-controller port between the CPU cache and NUM_DMA DMA requesters. Runs in the MCU clock domain.
- Drives the cache's grant input (dma_mcu_access) and multiplexes address, write-enable, activate and write data toward memory.
- Cache has priority, bounded by a starvation limit. DMA channels rotate round-robin.
- A read grant is held through the read beat window so the cache line fill is never interleaved with another requester.

Parameters:
NUM_DMA, 2, number of DMA requesters (1..4)
READ_BEATS, 4, MCU cycles the grant is held after mem_ack on a read (data streaming window)
STARVE_MAX, 3, consecutive cache grants allowed while any DMA request is pending

Ports:
MCU_CLK  in  1  clock; all state on posedge
RST  in  1  synchronous reset, active-high
c_req  in  1  cache wants the port (level, held until c_ack)
c_we  in  1  cache request is a write
c_addr  in  32  cache word address
c_wdata  in  32  cache write data
c_grant  out  1  cache owns the port (to cache dma_mcu_access)
c_ack  out  1  one-cycle pulse: cache request accepted by memory
d_req  in  NUM_DMA  per-channel request (level)
d_we  in  NUM_DMA  per-channel write flag
d_addr  in  32*NUM_DMA  per-channel address, channel i at [32i+31:32i]
d_wdata  in  32*NUM_DMA  per-channel write data
d_grant  out  NUM_DMA  one-hot channel grant
d_ack  out  NUM_DMA  one-cycle accept pulse per channel
mem_addr  out  32  address of owner
mem_we  out  1  write flag of owner
mem_do_act  out  1  activate toward memory controller
mem_dataintomem  out  32  write data of owner
mem_ack  in  1  memory controller accepted current activate

Behaviour:
- Reset (RST=1 at posedge): state IDLE; c_grant, d_grant, c_ack, d_ack, mem_do_act, mem_we = 0; mem_addr and mem_dataintomem = 0; rr pointer = 0; starve count = 0; beat counter = 0. Reset mid-transfer abandons the transfer; no ack is issued.
- State IDLE:
  - No request: remain in IDLE.
  - Winner selection: if c_req=1 and (starve<STARVE_MAX or no d_req), the cache wins. Otherwise the first d_req bit at or after the rr pointer, wrapping at NUM_DMA-1 to 0, wins.
  - On winning: the registered grant is asserted the next cycle and the state moves to OWN.
  - Arbitration latency: request to grant = 1 cycle.
- State OWN:
  - mem_do_act = owner's req AND grant (combinational from the registered grant).
  - mem_addr, mem_we and mem_dataintomem are muxed from the owner. Mux outputs are 0 when there is no owner.
- mem_ack in OWN:
  - The owner's ack pulses for 1 cycle on the following cycle (mem_ack is registered internally).
  - mem_do_act drops in the same cycle as the registered ack.
  - If the owner's we=0: go to HOLD with beat = READ_BEATS-1. Otherwise go to GAP.
- Owner drops req in OWN before mem_ack: abort, no ack, go to GAP. If req drop and mem_ack coincide, the ack wins and the transfer counts as complete.
- State HOLD: the grant stays asserted and mem_do_act = 0. beat decrements each cycle; at beat=0 go to GAP.
- State GAP: all grants deasserted for exactly 1 cycle, then IDLE. This gives the back-to-back minimum spacing between owners.
- Starvation counter:
  - +1 on each cache grant while any d_req is set, saturating at STARVE_MAX.
  - Cleared on any DMA grant, or when a cache grant occurs with d_req=0.
- rr pointer: on a DMA grant to channel i, the pointer becomes (i+1) mod NUM_DMA.
- mem_ack outside OWN is ignored. At most one grant bit is set in any cycle. c_grant and d_grant are never set together.

Test Plan:
- Reset then c_req=1, c_we=0, c_addr=0x100; mem_ack 2 cycles after mem_do_act -> c_grant at cycle 1; mem_addr=0x100; c_ack one pulse; grant held 4 cycles after ack; 1 gap cycle; back to IDLE.
- d_req=2'b11 continuously, c_req=0, writes with immediate mem_ack -> grant sequence ch0, ch1, ch0, ch1 with one-cycle gaps; d_ack alternates.
- c_req and d_req[0] both held continuously -> grants cache, cache, cache, ch0, cache, cache, cache, ch0 (STARVE_MAX=3).
- Cache granted, c_req dropped before mem_ack -> mem_do_act falls, no c_ack, GAP, next requester served.
- RST asserted in HOLD with beat=2 -> next cycle all grants and mem_do_act = 0; state IDLE; pending c_req re-arbitrated 1 cycle after RST release.
- mem_ack pulsed while IDLE with no requests -> no ack outputs, no state change.
